// File: rtl/instr_dispatch_fsm_pkg.sv
// Shared encodings for the instruction dispatcher: FSM state codes, opCode ranges
// and the bit positions of the instruction word fields.
package instr_dispatch_fsm_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;
  localparam logic [2:0] ST_ERROR  = 3'd5;

  localparam logic [3:0] OPC_ALUI_MAX = 4'd7;
  localparam logic [3:0] OPC_ALU_MAX  = 4'd14;
  localparam logic [3:0] OPC_HALT     = 4'd15;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RI_MSB  = 11;
  localparam int RI_LSB  = 6;
  localparam int NUM_MSB = 5;
  localparam int NUM_LSB = 0;

endpackage

// File: rtl/instr_dispatch_fsm.sv
// Issue side of the execution-FSM start/done handshake: accepts an instruction word,
// pulses the start of the immediate-ALU or register-ALU FSM and retires on its done.
module instr_dispatch_fsm
  import instr_dispatch_fsm_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [3:0]       opCode,
  output logic [5:0]       Ri,
  output logic [5:0]       num,
  output logic             alui_start,
  output logic             alu_start,
  input  logic             alui_done,
  input  logic             alu_done,
  input  logic             resume,
  input  logic             clear_err,
  output logic             busy,
  output logic             halted,
  output logic             err_timeout,
  output logic [CNT_W-1:0] retire_cnt
);

  logic [2:0]       state_q, state_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [5:0]       ri_q, ri_d;
  logic [5:0]       num_q, num_d;
  logic             use_alu_q, use_alu_d;
  logic             alui_start_q, alui_start_d;
  logic             alu_start_q, alu_start_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic             sel_done;

  // Only the unit that was actually started may complete the instruction.
  assign sel_done = use_alu_q ? alu_done : alui_done;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch is inferred.
    state_d      = state_q;
    opcode_d     = opcode_q;
    ri_d         = ri_q;
    num_d        = num_q;
    use_alu_d    = use_alu_q;
    alui_start_d = 1'b0;
    alu_start_d  = 1'b0;
    to_cnt_d     = to_cnt_q;
    err_d        = err_q;
    retire_d     = retire_q;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          opcode_d = instr[OPC_MSB:OPC_LSB];
          ri_d     = instr[RI_MSB:RI_LSB];
          num_d    = instr[NUM_MSB:NUM_LSB];
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode_q <= OPC_ALU_MAX) begin
          use_alu_d    = (opcode_q > OPC_ALUI_MAX);
          alui_start_d = (opcode_q <= OPC_ALUI_MAX);
          alu_start_d  = (opcode_q > OPC_ALUI_MAX);
          state_d      = ST_ISSUE;
        end else begin
          // HALT has no execution unit; it retires on entry to HALTED.
          retire_d = retire_q + CNT_W'(1);
          state_d  = ST_HALTED;
        end
      end
      ST_ISSUE: begin
        to_cnt_d = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (sel_done) begin
          retire_d = retire_q + CNT_W'(1);
          state_d  = ST_IDLE;
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_HALTED: begin
        if (resume) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        if (clear_err) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      opcode_q     <= '0;
      ri_q         <= '0;
      num_q        <= '0;
      use_alu_q    <= 1'b0;
      alui_start_q <= 1'b0;
      alu_start_q  <= 1'b0;
      to_cnt_q     <= '0;
      err_q        <= 1'b0;
      retire_q     <= '0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      ri_q         <= ri_d;
      num_q        <= num_d;
      use_alu_q    <= use_alu_d;
      alui_start_q <= alui_start_d;
      alu_start_q  <= alu_start_d;
      to_cnt_q     <= to_cnt_d;
      err_q        <= err_d;
      retire_q     <= retire_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign halted      = (state_q == ST_HALTED);
  assign opCode      = opcode_q;
  assign Ri          = ri_q;
  assign num         = num_q;
  assign alui_start  = alui_start_q;
  assign alu_start   = alu_start_q;
  assign err_timeout = err_q;
  assign retire_cnt  = retire_q;

endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// Self-checking bench for instr_dispatch_fsm: directed handshake scenarios plus randomized
// instructions compared against a transaction-level model of the dispatcher.
module tb_instr_dispatch_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  opCode;
  logic [5:0]  Ri;
  logic [5:0]  num;
  logic        alui_start;
  logic        alu_start;
  logic        alui_done;
  logic        alu_done;
  logic        resume;
  logic        clear_err;
  logic        busy;
  logic        halted;
  logic        err_timeout;
  logic [15:0] retire_cnt;

  int          checks_total  = 0;
  int          checks_passed = 0;
  logic [15:0] exp_retire;

  instr_dispatch_fsm #(.TIMEOUT(64), .TO_W(7), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opCode      (opCode),
    .Ri          (Ri),
    .num         (num),
    .alui_start  (alui_start),
    .alu_start   (alu_start),
    .alui_done   (alui_done),
    .alu_done    (alu_done),
    .resume      (resume),
    .clear_err   (clear_err),
    .busy        (busy),
    .halted      (halted),
    .err_timeout (err_timeout),
    .retire_cnt  (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ":ready"},  32'(instr_ready), 32'd1);
    check({tag, ":busy"},   32'(busy), 32'd0);
    check({tag, ":halted"}, 32'(halted), 32'd0);
    check({tag, ":err"},    32'(err_timeout), 32'd0);
    check({tag, ":retire"}, 32'(retire_cnt), 32'(exp_retire));
  endtask

  // Model: opCode 0..7 -> immediate ALU, 8..14 -> register ALU, 15 -> halt.
  // Start is high in the second cycle after the accepting edge; done retires in WAIT only.
  task automatic run_instr(input logic [3:0] opc, input logic [5:0] ri, input logic [5:0] imm,
                           input int delay, input bit noise);
    logic [15:0] w;
    logic [1:0]  exp_start;
    bit          to_alu;
    w      = {opc, ri, imm};
    to_alu = (opc >= 4'd8) && (opc <= 4'd14);
    exp_start = to_alu ? 2'b01 : 2'b10;
    if (noise) begin
      repeat ($urandom_range(0, 2)) begin
        alui_done = 1'($urandom);
        alu_done  = 1'($urandom);
        step();
        check_idle("idle_noise");
      end
    end
    alui_done = 1'b0;
    alu_done  = 1'b0;
    check_idle("pre");
    instr       = w;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    if (noise) begin
      alui_done = 1'($urandom);
      alu_done  = 1'($urandom);
    end
    check("dec_busy", 32'(busy), 32'd1);
    check("dec_ready", 32'(instr_ready), 32'd0);
    check("dec_fields", 32'({opCode, Ri, num}), 32'(w));
    check("dec_starts", 32'({alui_start, alu_start}), 32'd0);
    step();
    if (opc == 4'd15) begin
      exp_retire++;
      alui_done = 1'b0;
      alu_done  = 1'b0;
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_ready", 32'(instr_ready), 32'd0);
      check("halt_starts", 32'({alui_start, alu_start}), 32'd0);
      for (int i = 0; i < delay; i++) begin
        clear_err = 1'($urandom);
        alui_done = 1'($urandom);
        alu_done  = 1'($urandom);
        step();
        check("halt_hold", 32'({halted, instr_ready, alui_start, alu_start}), 32'b1000);
      end
      clear_err = 1'b0;
      alui_done = 1'b0;
      alu_done  = 1'b0;
      resume    = 1'b1;
      step();
      resume = 1'b0;
      check_idle("halt_exit");
    end else begin
      if (noise) begin
        alui_done = 1'($urandom);
        alu_done  = 1'($urandom);
      end
      check("issue_starts", 32'({alui_start, alu_start}), 32'(exp_start));
      check("issue_ready", 32'(instr_ready), 32'd0);
      step();
      alui_done = 1'b0;
      alu_done  = 1'b0;
      check("wait_starts", 32'({alui_start, alu_start}), 32'd0);
      for (int i = 0; i < delay; i++) begin
        if (noise) begin
          if (to_alu) alui_done = 1'($urandom);
          else        alu_done  = 1'($urandom);
        end
        step();
        check("wait_hold", 32'({busy, instr_ready, alui_start, alu_start}), 32'b1000);
      end
      alui_done = !to_alu;
      alu_done  = to_alu;
      step();
      alui_done = 1'b0;
      alu_done  = 1'b0;
      exp_retire++;
      check_idle("retire");
    end
    check("hold_fields", 32'({opCode, Ri, num}), 32'(w));
  endtask

  // The 64th WAIT cycle either sees done (retire wins) or times out into ERROR.
  task automatic run_timeout(input bit done_at_last);
    logic [3:0] opc;
    bit         to_alu;
    opc    = 4'($urandom_range(0, 14));
    to_alu = (opc >= 4'd8);
    instr       = {opc, 6'($urandom), 6'($urandom)};
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    step();
    alui_done = to_alu;
    alu_done  = !to_alu;
    repeat (63) step();
    check("to_pre_err", 32'(err_timeout), 32'd0);
    check("to_pre_busy", 32'({busy, instr_ready}), 32'b10);
    if (done_at_last) begin
      alui_done = !to_alu;
      alu_done  = to_alu;
      step();
      alui_done = 1'b0;
      alu_done  = 1'b0;
      exp_retire++;
      check_idle("to_done_wins");
    end else begin
      step();
      alui_done = 1'b0;
      alu_done  = 1'b0;
      check("to_err", 32'(err_timeout), 32'd1);
      check("to_err_state", 32'({busy, instr_ready, halted}), 32'b100);
      resume = 1'b1;
      repeat (3) step();
      resume = 1'b0;
      check("to_resume_ignored", 32'({err_timeout, instr_ready}), 32'b10);
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
      check_idle("to_cleared");
    end
  endtask

  task automatic run_back_to_back();
    logic [15:0] b2b [3];
    bit          done_pend;
    bit          acc;
    int          starts;
    int          idx;
    b2b[0]    = 16'h1041;
    b2b[1]    = 16'h2082;
    b2b[2]    = 16'h30C3;
    done_pend = 1'b0;
    starts    = 0;
    idx       = 0;
    instr       = b2b[0];
    instr_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      acc       = instr_ready && instr_valid;
      alui_done = done_pend;
      done_pend = 1'b0;
      if (alui_start) begin
        starts++;
        done_pend = 1'b1;
      end
      if (alu_start) starts += 100;
      check("b2b_ready_vs_busy", 32'(instr_ready), 32'(!busy));
      step();
      if (acc) begin
        idx++;
        if (idx < 3) instr = b2b[idx];
        else instr_valid = 1'b0;
      end
    end
    alui_done = 1'b0;
    exp_retire += 16'd3;
    check("b2b_accepts", 32'(idx), 32'd3);
    check("b2b_starts", 32'(starts), 32'd3);
    check_idle("b2b_end");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    alui_done   = 1'b0;
    alu_done    = 1'b0;
    resume      = 1'b0;
    clear_err   = 1'b0;
    exp_retire  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 32'({busy, halted, err_timeout, alui_start, alu_start}), 32'd0);
    check("rst_fields", 32'({opCode, Ri, num}), 32'd0);
    check("rst_retire", 32'(retire_cnt), 32'd0);
    reset = 1'b1;
    step();
    check_idle("post_reset");

    run_instr(4'd5, 6'd0, 6'd63, 3, 1'b0);
    run_instr(4'd9, 6'd17, 6'd42, 5, 1'b1);
    run_instr(4'd15, 6'd3, 6'd4, 4, 1'b1);
    run_instr(4'd7, 6'd63, 6'd1, 0, 1'b0);
    run_instr(4'd14, 6'd1, 6'd0, 0, 1'b1);
    run_instr(4'd8, 6'd2, 6'd2, 2, 1'b1);
    run_timeout(1'b0);
    run_timeout(1'b1);

    for (int k = 0; k < 40; k++) begin
      run_instr(4'($urandom_range(0, 15)), 6'($urandom), 6'($urandom),
                int'($urandom_range(0, 12)), 1'($urandom));
    end

    run_back_to_back();

    // Asynchronous reset while an instruction is outstanding in WAIT.
    instr       = 16'h4ABC;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    step();
    step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #2;
    check("mid_rst_outputs", 32'({busy, halted, err_timeout, alui_start, alu_start}), 32'd0);
    check("mid_rst_fields", 32'({opCode, Ri, num}), 32'd0);
    check("mid_rst_retire", 32'(retire_cnt), 32'd0);
    exp_retire = '0;
    reset = 1'b1;
    step();
    check_idle("after_mid_rst");
    alui_done = 1'b1;
    step();
    alui_done = 1'b0;
    check_idle("stale_done_ignored");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
